gt_int_serial_ctrl: RTL and testbench

GT_INT_SERIAL_CTRL -- requirements
Module: gt_int_serial_ctrl

---
 rtl/gt_serial_pkg.sv | 21 ++
 rtl/gt_chunk_cmp.sv | 33 +++
 rtl/gt_int_serial_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gt_int_serial_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/gt_serial_pkg.sv
// Shared definitions for the bit-serial signed greater-than controller:
// FSM state encoding and sizing helpers for the chunk index and counter.
package gt_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Bits needed to count 0..n inclusive (never less than 1).
    function automatic int cnt_w_f(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gt_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// IMPL_TYPE 0: relational operators; IMPL_TYPE 1: borrow of a subtraction.
module gt_chunk_cmp
    import gt_serial_pkg::*;
#(
    parameter int CHUNK     = 2,
    parameter int IMPL_TYPE = 0
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);

    generate
        if (IMPL_TYPE == 1) begin : g_sub
            logic [CHUNK:0] diff_s;
            // Borrow-out says a<b; a nonzero difference without borrow says a>b.
            always_comb begin
                diff_s = {1'b0, a} - {1'b0, b};
                lt     = diff_s[CHUNK];
                gt     = ~diff_s[CHUNK] & (|diff_s[CHUNK-1:0]);
            end
        end else begin : g_rel
            // Plain magnitude comparison.
            always_comb begin
                gt = (a > b);
                lt = (a < b);
            end
        end
    endgenerate

endmodule

// File: rtl/gt_int_serial_ctrl.sv
// Bit-serial signed A > B comparator with valid/ready handshakes on both sides.
// Operands are sign-biased (MSB inverted) on capture so that an unsigned
// MSB-first chunk scan yields the signed ordering.
// Optional feature: define GT_SERIAL_EARLY_EXIT_EN to stop scanning at the
// first unequal chunk; otherwise every chunk is scanned (fixed latency).
module gt_int_serial_ctrl
    import gt_serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHUNK     = 2,
    parameter int IMPL_TYPE = 0,
    localparam int NCHUNK   = nchunk_f(WIDTH, CHUNK),
    localparam int CW       = cnt_w_f(NCHUNK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y,
    output logic [CW-1:0]    chunk_cnt
);

    localparam int IW = cnt_w_f(NCHUNK);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("gt_int_serial_ctrl: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             dec_q, dec_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CHUNK-1:0] a_chunk_s, b_chunk_s;
    logic             gt_s, lt_s, last_s;

    // Select the biased chunk currently addressed by idx.
    always_comb begin
        a_chunk_s = '0;
        b_chunk_s = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                a_chunk_s = a_q[i*CHUNK +: CHUNK];
                b_chunk_s = b_q[i*CHUNK +: CHUNK];
            end else begin
                a_chunk_s = a_chunk_s;
                b_chunk_s = b_chunk_s;
            end
        end
    end

    gt_chunk_cmp #(
        .CHUNK     (CHUNK),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_cmp (
        .a  (a_chunk_s),
        .b  (b_chunk_s),
        .gt (gt_s),
        .lt (lt_s)
    );

    // Decide whether the current SCAN cycle is the final one.
    always_comb begin
`ifdef GT_SERIAL_EARLY_EXIT_EN
        last_s = gt_s | lt_s | (idx_q == '0);
`else
        last_s = (idx_q == '0);
`endif
    end

    // Next-state logic: capture, serial scan, and result hold.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        dec_d   = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = A ^ SIGN_MASK;
                    b_d     = B ^ SIGN_MASK;
                    idx_d   = IW'(NCHUNK - 1);
                    cnt_d   = '0;
                    y_d     = 1'b0;
                    dec_d   = 1'b0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + CW'(1);
                // Only the most significant unequal chunk decides the result.
                if (!dec_q && (gt_s || lt_s)) begin
                    y_d   = gt_s;
                    dec_d = 1'b1;
                end else begin
                    y_d   = y_q;
                end
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything including the handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            y_q         <= 1'b0;
            dec_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            dec_q       <= dec_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign chunk_cnt = cnt_q;

endmodule

// File: tb/tb_gt_int_serial_ctrl.sv
// Directed bench for gt_int_serial_ctrl (WIDTH=8, CHUNK=2).
// Expected latency/chunk counts follow GT_SERIAL_EARLY_EXIT_EN when defined.
module tb_gt_int_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       out_valid;
    logic       out_ready;
    logic       y_s;
    logic [2:0] cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    gt_int_serial_ctrl #(
        .WIDTH     (8),
        .CHUNK     (2),
        .IMPL_TYPE (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_s),
        .B         (b_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (y_s),
        .chunk_cnt (cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair, wait for out_valid, check result (left in DONE).
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic exp_y, input int ee_cnt);
        int lat;
        int exp_cnt;
        logic got;
`ifdef GT_SERIAL_EARLY_EXIT_EN
        exp_cnt = ee_cnt;
`else
        exp_cnt = 4;
`endif
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        a_s = a;
        b_s = b;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            a_s = 8'($urandom);
            b_s = 8'($urandom);
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk({tag, "_done"}, got, 1);
        chk({tag, "_lat"}, lat, exp_cnt + 1);
        chk({tag, "_y"}, y_s, exp_y);
        chk({tag, "_cnt"}, cnt_s, exp_cnt);
        chk({tag, "_busy"}, in_ready, 0);
    endtask

    // Complete the result handshake and check the return to IDLE.
    task automatic release_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_low"}, out_valid, 0);
        chk({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        int ov_seen;
        int exp_c;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_s = 8'h00;
        b_s = 8'h00;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y_s, 0);
        chk("rst_cnt", cnt_s, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", in_ready, 0);
        @(posedge clk); #1;
        chk("rel_in_ready_post", in_ready, 1);

        do_op("pos_vs_neg", 8'h05, 8'hFB, 1'b1, 1); release_op("pos_vs_neg");
        do_op("min_vs_max", 8'h80, 8'h7F, 1'b0, 1); release_op("min_vs_max");
        do_op("max_vs_min", 8'h7F, 8'h80, 1'b1, 1); release_op("max_vs_min");
        do_op("equal33", 8'h33, 8'h33, 1'b0, 4); release_op("equal33");
        do_op("neg_vs_neg", 8'hC0, 8'hB0, 1'b1, 1); release_op("neg_vs_neg");
        do_op("mid_chunk", 8'h24, 8'h2C, 1'b0, 3); release_op("mid_chunk");
        do_op("lsb_only", 8'h01, 8'h00, 1'b1, 4); release_op("lsb_only");

        // Hold DONE with out_ready low; in_valid and operands wiggle meanwhile.
`ifdef GT_SERIAL_EARLY_EXIT_EN
        exp_c = 4;
`else
        exp_c = 4;
`endif
        do_op("hold", 8'hFF, 8'hFE, 1'b1, 4);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a_s = 8'($urandom);
            b_s = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_ov", out_valid, 1);
            chk("hold_y", y_s, 1);
            chk("hold_cnt", cnt_s, exp_c);
            chk("hold_rdy", in_ready, 0);
        end
        release_op("hold");
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_no_accept", in_ready, 1);

        // Asynchronous reset in the middle of a scan.
        in_valid = 1'b1;
        a_s = 8'h24;
        b_s = 8'h2C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        chk("scan_cnt_before", cnt_s, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_y", y_s, 0);
        chk("arst_cnt", cnt_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        chk("arst_no_ov", ov_seen, 0);
        do_op("after_rst", 8'h05, 8'hFB, 1'b1, 1); release_op("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
